// File: rtl/tama_pkg.sv
// Shared definitions for the pet command path: ASCII framing constants,
// decoder FSM states and the latched command encoding.
package tama_pkg;

  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_R    = 8'h52;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_WAIT_CMD,
    CMD_WAIT_TERM
  } cmd_state_t;

  typedef enum logic [2:0] {
    OP_FEED,
    OP_PLAY,
    OP_CLEAN,
    OP_HEAL,
    OP_SLEEP,
    OP_REPORT
  } cmd_op_t;

  function automatic logic is_cmd_letter(input logic [7:0] b);
    return (b == CH_F) || (b == CH_P) || (b == CH_C) ||
           (b == CH_M) || (b == CH_S) || (b == CH_R);
  endfunction

  function automatic logic is_terminator(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic cmd_op_t letter_to_op(input logic [7:0] b);
    cmd_op_t op;
    case (b)
      CH_P:    op = OP_PLAY;
      CH_C:    op = OP_CLEAN;
      CH_M:    op = OP_HEAL;
      CH_S:    op = OP_SLEEP;
      CH_R:    op = OP_REPORT;
      default: op = OP_FEED;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the UART receiver's level-held byte output into a single-cycle
// strobe on the zero-to-nonzero transition.
module rx_byte_strobe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  output logic       strobe
);

  logic [7:0] prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 8'd0;
    else        prev <= rx_byte;
  end

  assign strobe = (rx_byte != 8'd0) && (prev == 8'd0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes "!<letter><CR|LF>" frames into action pulses and a report hold.
// Define CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle.
module uart_cmd_decoder
  import tama_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 27_000_000,
  parameter int REPORT_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       is_sleeping,
  output logic       feed,
  output logic       play,
  output logic       clean,
  output logic       heal,
  output logic       sleep_toggle,
  output logic       report_n,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int HW = (REPORT_HOLD > 1) ? $clog2(REPORT_HOLD + 1) : 1;

  cmd_state_t    state, next_state;
  cmd_op_t       op;
  logic          strobe;
  logic          timeout_hit;
  logic          latch_op;
  logic          fire;
  logic          err_inc;
  logic          gated;
  logic          accept;
  logic          start_report;
  logic [HW-1:0] hold_cnt;

  rx_byte_strobe u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_byte(rx_byte),
    .strobe (strobe)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timeout_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      timeout_cnt <= '0;
    else if (strobe || (state == CMD_IDLE) || timeout_hit)
      timeout_cnt <= '0;
    else
      timeout_cnt <= timeout_cnt + 1'b1;
  end

  assign timeout_hit = (state != CMD_IDLE) && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Referenced only so the parameter remains part of the interface.
  localparam bit timeout_unused = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = 1'b0;
`endif

  assign gated  = is_sleeping &&
                  ((op == OP_FEED) || (op == OP_PLAY) || (op == OP_CLEAN) || (op == OP_HEAL));
  assign accept = fire && !gated;
  assign start_report = accept && (op == OP_REPORT) && report_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CMD_IDLE;
      op    <= OP_FEED;
    end else begin
      state <= next_state;
      if (latch_op) op <= letter_to_op(rx_byte);
    end
  end

  // A strobe in the same cycle as the timeout takes priority over the abort.
  always_comb begin
    next_state = state;
    latch_op   = 1'b0;
    fire       = 1'b0;
    err_inc    = 1'b0;
    case (state)
      CMD_IDLE: begin
        if (strobe && (rx_byte == CH_BANG)) next_state = CMD_WAIT_CMD;
      end
      CMD_WAIT_CMD: begin
        if (strobe) begin
          if (rx_byte == CH_BANG) begin
            next_state = CMD_WAIT_CMD;
          end else if (is_cmd_letter(rx_byte)) begin
            latch_op   = 1'b1;
            next_state = CMD_WAIT_TERM;
          end else begin
            err_inc    = 1'b1;
            next_state = CMD_IDLE;
          end
        end else if (timeout_hit) begin
          err_inc    = 1'b1;
          next_state = CMD_IDLE;
        end
      end
      CMD_WAIT_TERM: begin
        if (strobe) begin
          if (is_terminator(rx_byte)) begin
            fire       = 1'b1;
            err_inc    = gated;
            next_state = CMD_IDLE;
          end else if (rx_byte == CH_BANG) begin
            next_state = CMD_WAIT_CMD;
          end else begin
            err_inc    = 1'b1;
            next_state = CMD_IDLE;
          end
        end else if (timeout_hit) begin
          err_inc    = 1'b1;
          next_state = CMD_IDLE;
        end
      end
      default: next_state = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      feed         <= 1'b0;
      play         <= 1'b0;
      clean        <= 1'b0;
      heal         <= 1'b0;
      sleep_toggle <= 1'b0;
    end else begin
      feed         <= accept && (op == OP_FEED);
      play         <= accept && (op == OP_PLAY);
      clean        <= accept && (op == OP_CLEAN);
      heal         <= accept && (op == OP_HEAL);
      sleep_toggle <= accept && (op == OP_SLEEP);
    end
  end

  // Hold counter runs down from REPORT_HOLD-1; a repeat R mid-hold is absorbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      report_n <= 1'b1;
      hold_cnt <= '0;
    end else if (start_report) begin
      report_n <= 1'b0;
      hold_cnt <= HW'(REPORT_HOLD - 1);
    end else if (!report_n) begin
      if (hold_cnt == '0) report_n <= 1'b1;
      else                hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (err_inc && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end

  assign busy = (state != CMD_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: frames push expected pulses with
// their expected cycle, and a negedge monitor pops and compares them.
module tb_uart_cmd_decoder;
  import tama_pkg::*;

  localparam int HOLD = 16;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       is_sleeping = 1'b0;
  logic       feed, play, clean, heal, sleep_toggle, report_n, busy;
  logic [7:0] err_count;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .REPORT_HOLD(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .is_sleeping (is_sleeping),
    .feed        (feed),
    .play        (play),
    .clean       (clean),
    .heal        (heal),
    .sleep_toggle(sleep_toggle),
    .report_n    (report_n),
    .err_count   (err_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] act;
    int         at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_err = 0;
  int   hold_end = -1;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Action bit order: {report fall, feed, play, clean, heal, sleep_toggle}
  function automatic logic [5:0] exp_act(input logic [7:0] letter, input logic sleeping);
    logic [5:0] a;
    case (letter)
      CH_F:    a = sleeping ? 6'b000000 : 6'b010000;
      CH_P:    a = sleeping ? 6'b000000 : 6'b001000;
      CH_C:    a = sleeping ? 6'b000000 : 6'b000100;
      CH_M:    a = sleeping ? 6'b000000 : 6'b000010;
      CH_S:    a = 6'b000001;
      CH_R:    a = 6'b100000;
      default: a = 6'b000000;
    endcase
    return a;
  endfunction

  logic       prev_rep = 1'b1;
  int         low_cnt = 0;
  logic [5:0] mon_act;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon_act = {prev_rep && !report_n, feed, play, clean, heal, sleep_toggle};
      if (!report_n) begin
        low_cnt++;
      end else if (!prev_rep) begin
        checks++;
        if (low_cnt != HOLD) begin
          errors++;
          $display("[TB] FAIL report_hold_len: got %0d cycles want %0d", low_cnt, HOLD);
        end
        low_cnt = 0;
      end
      if (mon_act != 6'd0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_action: got %b at cycle %0d want none", mon_act, cyc);
        end else begin
          mon_e = q.pop_front();
          if (mon_act !== mon_e.act || cyc != mon_e.at) begin
            errors++;
            $display("[TB] FAIL action: got %b at cycle %0d want %b at cycle %0d",
                     mon_act, cyc, mon_e.act, mon_e.at);
          end
        end
      end
      prev_rep = report_n;
    end else begin
      prev_rep = 1'b1;
      low_cnt  = 0;
    end
  end

  task automatic clear_model();
    q.delete();
    exp_err  = 0;
    hold_end = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int held);
    rx_byte = b;
    repeat (held) @(negedge clk);
    rx_byte = 8'd0;
    @(negedge clk);
  endtask

  task automatic send_tail(input logic [7:0] letter, input logic [7:0] term, input int held);
    logic [5:0] a;
    int         at;
    exp_t       e;
    send_byte(letter, held);
    a  = exp_act(letter, is_sleeping);
    at = cyc + 1;
    if (a == 6'd0) begin
      if (exp_err < 255) exp_err++;
    end else if (a == 6'b100000) begin
      if (at > hold_end) begin
        e.act = a; e.at = at; q.push_back(e);
        hold_end = at + HOLD - 1;
      end
    end else begin
      e.act = a; e.at = at; q.push_back(e);
    end
    send_byte(term, held);
  endtask

  task automatic send_frame(input logic [7:0] letter, input logic [7:0] term, input int held);
    send_byte(CH_BANG, held);
    send_tail(letter, term, held);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0 && cyc > hold_end + 1) break;
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_missing_actions: got %0d pending want 0", name, q.size());
    end
    checks++;
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("[TB] FAIL %s_err_count: got %0d want %0d", name, err_count, exp_err);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({feed, play, clean, heal, sleep_toggle} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL %s_pulses: got %b want 00000", name, {feed, play, clean, heal, sleep_toggle});
    end
    checks++;
    if (report_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_report_n: got %b want 1", name, report_n);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL %s_err_count: got %0d want 0", name, err_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rx_byte = 8'd0;
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");
    // '!' already on the line when reset releases must count as a new byte
    rst_n  = 1'b0;
    mon_en = 1'b0;
    rx_byte = CH_BANG;
    repeat (2) @(negedge clk);
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_strobe_busy: got %b want 1", busy);
    end
    rx_byte = 8'd0;
    @(negedge clk);
    send_tail(CH_F, CH_CR, 1);
    drain("release_strobe");
  endtask

  task automatic test_commands();
    logic [7:0] letters [5];
    $display("[TB] test_commands");
    letters = '{CH_F, CH_P, CH_C, CH_M, CH_S};
    is_sleeping = 1'b0;
    do_reset();
    send_frame(CH_F, CH_CR, 5);
    for (int i = 0; i < 5; i++)
      send_frame(letters[i], (i % 2 == 0) ? CH_LF : CH_CR, 1 + (i % 3));
    drain("commands");
  endtask

  task automatic test_report();
    $display("[TB] test_report");
    do_reset();
    send_frame(CH_R, CH_LF, 1);
    send_frame(CH_R, CH_LF, 1);
    drain("report_repeat");
    send_frame(CH_R, CH_CR, 1);
    drain("report_again");
  endtask

  task automatic test_errors();
    $display("[TB] test_errors");
    do_reset();
    send_byte(CH_BANG, 1);
    send_byte(8'h58, 1);
    if (exp_err < 255) exp_err++;
    send_byte(CH_CR, 1);
    send_byte(CH_BANG, 1);
    send_byte(CH_F, 1);
    send_byte(8'h51, 1);
    if (exp_err < 255) exp_err++;
    drain("bad_frames");
    checks++;
    if (err_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL bad_frames_two: got %0d want 2", err_count);
    end
    send_byte(8'h41, 1);
    send_byte(CH_LF, 1);
    send_byte(CH_BANG, 1);
    send_frame(CH_F, CH_CR, 1);
    send_byte(CH_BANG, 1);
    send_byte(CH_F, 1);
    send_frame(CH_P, CH_LF, 1);
    send_byte(CH_BANG, 1);
    send_byte(8'h66, 1);
    if (exp_err < 255) exp_err++;
    send_byte(CH_CR, 1);
    drain("rebang");
  endtask

  task automatic test_sleep();
    $display("[TB] test_sleep");
    do_reset();
    is_sleeping = 1'b1;
    send_frame(CH_P, CH_CR, 1);
    drain("sleep_play");
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL sleep_play_err: got %0d want 1", err_count);
    end
    send_frame(CH_S, CH_CR, 1);
    send_frame(CH_R, CH_LF, 1);
    send_frame(CH_F, CH_LF, 1);
    send_frame(CH_C, CH_CR, 1);
    send_frame(CH_M, CH_CR, 1);
    drain("sleep_mix");
    is_sleeping = 1'b0;
  endtask

  task automatic test_timeout();
    int bang_cyc;
    $display("[TB] test_timeout");
    do_reset();
    bang_cyc = cyc;
    send_byte(CH_BANG, 1);
`ifdef CMD_TIMEOUT_EN
    for (int i = 0; i < 3 * TMO; i++) begin
      if (busy !== 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || cyc != bang_cyc + TMO + 1) begin
      errors++;
      $display("[TB] FAIL timeout_return: got busy=%b at cycle %0d want busy=0 at cycle %0d",
               busy, cyc, bang_cyc + TMO + 1);
    end
    exp_err++;
    drain("timeout");
`else
    repeat (1000) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_timeout_busy: got %b want 1 (bang at cycle %0d)", busy, bang_cyc);
    end
    send_tail(CH_F, CH_CR, 1);
    drain("no_timeout");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_timeout_done_busy: got %b want 0", busy);
    end
`endif
  endtask

  task automatic test_reset_abort();
    $display("[TB] test_reset_abort");
    do_reset();
    send_byte(CH_BANG, 1);
    send_byte(CH_BANG, 1);
    send_byte(CH_C, 1);
    do_reset();
    send_byte(CH_CR, 1);
    repeat (4) @(negedge clk);
    check_idle_outputs("reset_abort");
  endtask

  task automatic test_saturate();
    $display("[TB] test_saturate");
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_byte(CH_BANG, 1);
      send_byte(8'h58, 1);
      if (exp_err < 255) exp_err++;
    end
    drain("saturate");
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL saturate_255: got %0d want 255", err_count);
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    do_reset();
    send_frame(CH_F, CH_CR, 1);
    send_frame(CH_P, CH_LF, 1);
    send_frame(CH_R, CH_CR, 1);
    send_frame(CH_C, CH_LF, 1);
    send_frame(CH_M, CH_CR, 1);
    send_frame(CH_S, CH_LF, 1);
    drain("back_to_back");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_commands();
    test_report();
    test_errors();
    test_sleep();
    test_timeout();
    test_reset_abort();
    test_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
